// File: rtl/if_id_queue_if.sv
// Fetch-to-decode instruction queue bus.
// Fetch side: if_valid/if_pc/if_inst in, if_ready out.
// Decode side: id_valid/id_pc/id_inst out, id_ready in.
// Control: flush in, count out (occupancy).
interface if_id_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          if_valid;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_inst;
  logic          if_ready;
  logic          id_valid;
  logic [AW-1:0] id_pc;
  logic [DW-1:0] id_inst;
  logic          id_ready;
  logic          flush;
  logic [CW-1:0] count;

  // Master: the fetch/decode/control environment around the queue.
  modport master (
    output if_valid, if_pc, if_inst, id_ready, flush,
    input  if_ready, id_valid, id_pc, id_inst, count
  );

  // Slave: the queue itself.
  modport slave (
    input  if_valid, if_pc, if_inst, id_ready, flush,
    output if_ready, id_valid, id_pc, id_inst, count
  );
endinterface

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular FIFO of
// {pc, inst} pairs with valid/ready handshakes on both sides and a flush that
// drops every queued entry. An empty queue presents pc=0 / inst=0 (MIPS nop).
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   q    - if_id_queue_if.slave (fetch push side, decode pop side, flush, count)
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input logic         clk,
  input logic         rst,
  if_id_queue_if.slave q
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] mem_pc   [DEPTH];
  logic [DW-1:0] mem_inst [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] count_q;

  logic ready_c;
  logic valid_c;
  logic push_c;
  logic pop_c;

  // Handshake status from registered occupancy only; ready held low in reset.
  assign ready_c = ~rst & (count_q < CW'(DEPTH));
  assign valid_c = (count_q != '0);
  assign push_c  = q.if_valid & ready_c & ~q.flush;
  assign pop_c   = valid_c & q.id_ready & ~q.flush;

  // Storage, pointers and occupancy; pointers wrap modulo DEPTH by width.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else if (q.flush) begin
      wp      <= '0;
      rp      <= '0;
      count_q <= '0;
    end else begin
      if (push_c) begin
        mem_pc[wp]   <= q.if_pc;
        mem_inst[wp] <= q.if_inst;
        wp           <= wp + PW'(1);
      end
      if (pop_c) begin
        rp <= rp + PW'(1);
      end
      if (push_c && !pop_c) begin
        count_q <= count_q + CW'(1);
      end else if (pop_c && !push_c) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Head entry, masked to a nop when empty so stale storage never leaks.
  assign q.id_pc    = valid_c ? mem_pc[rp]   : '0;
  assign q.id_inst  = valid_c ? mem_inst[rp] : '0;
  assign q.id_valid = valid_c;
  assign q.if_ready = ready_c;
  assign q.count    = count_q;

endmodule
